bsv_counter_bank: RTL and testbench

//  Bank of NCHAN independent WIDTH-bit counters sharing data buses, each with clear, set, add and subtract.

---
 rtl/bsv_counter_pkg.sv | 28 ++
 rtl/bsv_counter_lane.sv | 48 ++++
 rtl/bsv_counter_bank.sv | 51 +++++
 tb/tb_bsv_counter_bank.sv | 167 ++++++++++++++++
 4 files changed

// File: rtl/bsv_counter_pkg.sv
// bsv_counter_pkg: shared mode type and next-value arithmetic for the counter bank.
// Exports cnt_mode_e, MAX_W, cnt_res_t and cnt_next(cur, inc, dec, w, sat) -> {ovf, unf, value}.
package bsv_counter_pkg;
  typedef enum logic {CNT_WRAP = 1'b0, CNT_SAT = 1'b1} cnt_mode_e;
  localparam int MAX_W = 64;
  localparam int SUM_W = MAX_W + 2;
  typedef struct packed {
    logic ovf;
    logic unf;
    logic [MAX_W-1:0] value;
  } cnt_res_t;
  // Operands are zero-extended to MAX_W; w is the real counter width.
  // The signed sum is two bits wider than any operand, so it can never wrap.
  function automatic cnt_res_t cnt_next(input logic [MAX_W-1:0] cur, input logic [MAX_W-1:0] inc,
                                        input logic [MAX_W-1:0] dec, input int unsigned w,
                                        input cnt_mode_e sat);
    logic signed [SUM_W-1:0] s;
    logic [SUM_W-1:0] mx;
    cnt_res_t r;
    s = $signed({2'b00, cur}) + $signed({2'b00, inc}) - $signed({2'b00, dec});
    mx = (SUM_W'(1) << w) - SUM_W'(1);
    r.unf = s[SUM_W-1];
    r.ovf = !s[SUM_W-1] && ($unsigned(s) > mx);
    r.value = (sat == CNT_SAT) ? (r.ovf ? mx[MAX_W-1:0] : r.unf ? '0 : s[MAX_W-1:0])
                               : s[MAX_W-1:0] & mx[MAX_W-1:0];
    return r;
  endfunction
endpackage

// File: rtl/bsv_counter_lane.sv
// bsv_counter_lane: one counter channel with clear/set/add/subtract, sticky OVF and TC pulse.
// Ports: i_clk, i_rst_n (sync, active-low), i_clr/i_set/i_inc/i_dec enables, shared buses
// i_data_s/i_data_i/i_data_d/i_limit; o_cnt live value, o_ovf sticky flag, o_tc registered pulse.
module bsv_counter_lane
  import bsv_counter_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter logic [WIDTH-1:0] INIT = '0,
  parameter int SATURATE = 0
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_clr,
  input  logic             i_set,
  input  logic             i_inc,
  input  logic             i_dec,
  input  logic [WIDTH-1:0] i_data_s,
  input  logic [WIDTH-1:0] i_data_i,
  input  logic [WIDTH-1:0] i_data_d,
  input  logic [WIDTH-1:0] i_limit,
  output logic [WIDTH-1:0] o_cnt,
  output logic             o_ovf,
  output logic             o_tc
);
  localparam cnt_mode_e MODE = (SATURATE != 0) ? CNT_SAT : CNT_WRAP;
  logic [WIDTH-1:0] r_cnt, w_next;
  logic r_ovf, r_tc, w_arith, w_act;
  cnt_res_t w_res;
  assign w_res = cnt_next(MAX_W'(r_cnt), MAX_W'(i_inc ? i_data_i : '0),
                          MAX_W'(i_dec ? i_data_d : '0), WIDTH, MODE);
  assign w_arith = i_inc | i_dec;
  assign w_act = i_clr | i_set | w_arith;
  assign w_next = i_clr ? '0 : i_set ? i_data_s : w_arith ? w_res.value[WIDTH-1:0] : r_cnt;
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_cnt <= INIT;
      r_ovf <= 1'b0;
      r_tc  <= 1'b0;
    end else begin
      r_cnt <= w_next;
      r_ovf <= (i_clr | i_set) ? 1'b0 : r_ovf | (w_arith & (w_res.ovf | w_res.unf));
      r_tc  <= w_act && (w_next == i_limit);
    end
  end
  assign o_cnt = r_cnt;
  assign o_ovf = r_ovf;
  assign o_tc  = r_tc;
endmodule

// File: rtl/bsv_counter_bank.sv
// bsv_counter_bank: NCHAN independent WIDTH-bit counters with shared buses and registered read-back.
// Ports: i_clk, i_rst_n (sync, active-low), per-channel i_clr/i_set/i_inc/i_dec, shared
// i_data_s/i_data_i/i_data_d/i_limit, i_rd_sel; o_q_out registered read-back, o_q_all live state,
// o_tc terminal-count pulses, o_ovf sticky over/underflow flags.
module bsv_counter_bank
  import bsv_counter_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int NCHAN = 4,
  parameter int SEL_W = 2,
  parameter logic [WIDTH-1:0] INIT = '0,
  parameter int SATURATE = 0
) (
  input  logic                   i_clk,
  input  logic                   i_rst_n,
  input  logic [NCHAN-1:0]       i_clr,
  input  logic [NCHAN-1:0]       i_set,
  input  logic [WIDTH-1:0]       i_data_s,
  input  logic [NCHAN-1:0]       i_inc,
  input  logic [WIDTH-1:0]       i_data_i,
  input  logic [NCHAN-1:0]       i_dec,
  input  logic [WIDTH-1:0]       i_data_d,
  input  logic [WIDTH-1:0]       i_limit,
  input  logic [SEL_W-1:0]       i_rd_sel,
  output logic [WIDTH-1:0]       o_q_out,
  output logic [NCHAN*WIDTH-1:0] o_q_all,
  output logic [NCHAN-1:0]       o_tc,
  output logic [NCHAN-1:0]       o_ovf
);
  // Padded to the full select range so out-of-range selects read back zero.
  logic [WIDTH-1:0] w_cnt [2**SEL_W];
  logic [WIDTH-1:0] r_q;
  for (genvar i = 0; i < 2**SEL_W; i++) begin : g_ch
    if (i < NCHAN) begin : g_lane
      bsv_counter_lane #(.WIDTH(WIDTH), .INIT(INIT), .SATURATE(SATURATE)) u_lane (
        .i_clk(i_clk), .i_rst_n(i_rst_n), .i_clr(i_clr[i]), .i_set(i_set[i]),
        .i_inc(i_inc[i]), .i_dec(i_dec[i]), .i_data_s(i_data_s), .i_data_i(i_data_i),
        .i_data_d(i_data_d), .i_limit(i_limit), .o_cnt(w_cnt[i]), .o_ovf(o_ovf[i]),
        .o_tc(o_tc[i])
      );
      assign o_q_all[i*WIDTH +: WIDTH] = w_cnt[i];
    end else begin : g_pad
      assign w_cnt[i] = '0;
    end
  end
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) r_q <= INIT;
    else r_q <= w_cnt[i_rd_sel];
  end
  assign o_q_out = r_q;
endmodule

// File: tb/tb_bsv_counter_bank.sv
// tb_bsv_counter_bank: wrap and saturate instances checked against an arithmetic model and vectors.
module tb_bsv_counter_bank;
  logic clk = 1'b0;
  logic rst_n;
  logic [3:0] clr, set, inc, dec;
  logic [7:0] ds, di, dd, lim;
  logic [2:0] rd_sel;
  logic [7:0] q_out [2];
  logic [31:0] q_all [2];
  logic [3:0] tc [2], ovf [2];
  int passed = 0, total = 0;
  int m_cnt [2][4];
  bit m_ovf [2][4], m_tc [2][4];
  int m_q [2];

  always #5 clk = ~clk;

  for (genvar k = 0; k < 2; k++) begin : g_dut
    bsv_counter_bank #(.WIDTH(8), .NCHAN(4), .SEL_W(3), .INIT(8'd0), .SATURATE(k)) u_dut (
      .i_clk(clk), .i_rst_n(rst_n), .i_clr(clr), .i_set(set), .i_data_s(ds), .i_inc(inc),
      .i_data_i(di), .i_dec(dec), .i_data_d(dd), .i_limit(lim), .i_rd_sel(rd_sel),
      .o_q_out(q_out[k]), .o_q_all(q_all[k]), .o_tc(tc[k]), .o_ovf(ovf[k])
    );
  end

  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
    total++;
    if (a === e) passed++;
    else $display("FAIL %s: got 0x%0h, want 0x%0h", n, a, e);
  endtask

  task automatic model_step();
    for (int k = 0; k < 2; k++) begin
      if (!rst_n) begin
        m_q[k] = 0;
        for (int c = 0; c < 4; c++) begin
          m_cnt[k][c] = 0; m_ovf[k][c] = 0; m_tc[k][c] = 0;
        end
      end else begin
        m_q[k] = (rd_sel < 4) ? m_cnt[k][rd_sel] : 0;
        for (int c = 0; c < 4; c++) begin
          int s;
          bit act;
          act = clr[c] | set[c] | inc[c] | dec[c];
          if (clr[c]) begin
            m_cnt[k][c] = 0; m_ovf[k][c] = 0;
          end else if (set[c]) begin
            m_cnt[k][c] = int'(ds); m_ovf[k][c] = 0;
          end else if (inc[c] | dec[c]) begin
            s = m_cnt[k][c] + (inc[c] ? int'(di) : 0) - (dec[c] ? int'(dd) : 0);
            if (s > 255 || s < 0) m_ovf[k][c] = 1;
            m_cnt[k][c] = (k == 1) ? ((s > 255) ? 255 : (s < 0) ? 0 : s) : (s & 255);
          end
          m_tc[k][c] = act && (m_cnt[k][c] == int'(lim));
        end
      end
    end
  endtask

  task automatic compare();
    for (int k = 0; k < 2; k++) begin
      logic [31:0] ea;
      logic [3:0] et, eo;
      for (int c = 0; c < 4; c++) begin
        ea[c*8 +: 8] = 8'(m_cnt[k][c]);
        et[c] = m_tc[k][c];
        eo[c] = m_ovf[k][c];
      end
      chk($sformatf("model q_out[%0d]", k), 32'(q_out[k]), 32'(m_q[k]));
      chk($sformatf("model q_all[%0d]", k), q_all[k], ea);
      chk($sformatf("model tc[%0d]", k), 32'(tc[k]), 32'(et));
      chk($sformatf("model ovf[%0d]", k), 32'(ovf[k]), 32'(eo));
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
    compare();
  endtask

  task automatic idle();
    clr = '0; set = '0; inc = '0; dec = '0;
  endtask

  typedef struct {
    logic [3:0] clr, set, inc, dec;
    logic [7:0] ds, di, dd, lim;
    int ch;
    logic [7:0] ew, es;
    bit eow, eos, etc;
  } vec_t;
  vec_t vecs [14];

  initial begin
    vecs[0]  = '{4'h0, 4'h1, 4'h0, 4'h0, 8'd250, 8'd0,   8'd0, 8'd16, 0, 8'd250, 8'd250, 0, 0, 0};
    vecs[1]  = '{4'h0, 4'h0, 4'h1, 4'h0, 8'd0,   8'd10,  8'd0, 8'd16, 0, 8'd4,   8'd255, 1, 1, 0};
    vecs[2]  = '{4'h0, 4'h0, 4'h0, 4'h0, 8'd0,   8'd0,   8'd0, 8'd16, 0, 8'd4,   8'd255, 1, 1, 0};
    vecs[3]  = '{4'h1, 4'h0, 4'h0, 4'h0, 8'd0,   8'd0,   8'd0, 8'd16, 0, 8'd0,   8'd0,   0, 0, 0};
    vecs[4]  = '{4'h0, 4'h1, 4'h0, 4'h0, 8'd5,   8'd0,   8'd0, 8'd16, 0, 8'd5,   8'd5,   0, 0, 0};
    vecs[5]  = '{4'h0, 4'h0, 4'h0, 4'h1, 8'd0,   8'd0,   8'd9, 8'd16, 0, 8'd252, 8'd0,   1, 1, 0};
    vecs[6]  = '{4'h0, 4'h1, 4'h0, 4'h0, 8'd10,  8'd0,   8'd0, 8'd16, 0, 8'd10,  8'd10,  0, 0, 0};
    vecs[7]  = '{4'h0, 4'h0, 4'h1, 4'h0, 8'd0,   8'd255, 8'd0, 8'd16, 0, 8'd9,   8'd255, 1, 1, 0};
    vecs[8]  = '{4'h0, 4'h2, 4'h0, 4'h0, 8'd20,  8'd0,   8'd0, 8'd16, 1, 8'd20,  8'd20,  0, 0, 0};
    vecs[9]  = '{4'h0, 4'h0, 4'h2, 4'h2, 8'd0,   8'd7,   8'd3, 8'd16, 1, 8'd24,  8'd24,  0, 0, 0};
    vecs[10] = '{4'h4, 4'h4, 4'h4, 4'h0, 8'd99,  8'd5,   8'd0, 8'd16, 2, 8'd0,   8'd0,   0, 0, 0};
    vecs[11] = '{4'h0, 4'h8, 4'h0, 4'h0, 8'd15,  8'd0,   8'd0, 8'd16, 3, 8'd15,  8'd15,  0, 0, 0};
    vecs[12] = '{4'h0, 4'h0, 4'h8, 4'h0, 8'd0,   8'd1,   8'd0, 8'd16, 3, 8'd16,  8'd16,  0, 0, 1};
    vecs[13] = '{4'h0, 4'h0, 4'h0, 4'h0, 8'd0,   8'd0,   8'd0, 8'd16, 3, 8'd16,  8'd16,  0, 0, 0};

    rst_n = 1'b0; idle(); ds = '0; di = '0; dd = '0; lim = 8'd16; rd_sel = '0;
    tick();
    tick();
    rst_n = 1'b1;

    foreach (vecs[v]) begin
      clr = vecs[v].clr; set = vecs[v].set; inc = vecs[v].inc; dec = vecs[v].dec;
      ds = vecs[v].ds; di = vecs[v].di; dd = vecs[v].dd; lim = vecs[v].lim;
      tick();
      chk($sformatf("vec%0d wrap cnt", v), 32'(q_all[0][vecs[v].ch*8 +: 8]), 32'(vecs[v].ew));
      chk($sformatf("vec%0d sat cnt", v), 32'(q_all[1][vecs[v].ch*8 +: 8]), 32'(vecs[v].es));
      chk($sformatf("vec%0d wrap ovf", v), 32'(ovf[0][vecs[v].ch]), 32'(vecs[v].eow));
      chk($sformatf("vec%0d sat ovf", v), 32'(ovf[1][vecs[v].ch]), 32'(vecs[v].eos));
      chk($sformatf("vec%0d tc", v), 32'({tc[1][vecs[v].ch], tc[0][vecs[v].ch]}),
          32'({vecs[v].etc, vecs[v].etc}));
    end

    idle(); rd_sel = 3'd2; inc = 4'h4; di = 8'd3;
    tick();
    chk("rd pre-update", 32'(q_out[0]), 32'd0);
    chk("rd ch2 updated", 32'(q_all[0][23:16]), 32'd3);
    idle();
    tick();
    chk("rd latency", 32'(q_out[0]), 32'd3);
    rd_sel = 3'd5;
    tick();
    chk("rd out of range", 32'({q_out[1], q_out[0]}), 32'd0);
    rd_sel = 3'd3;
    tick();
    chk("rd ch3", 32'(q_out[1]), 32'd16);
    rst_n = 1'b0; clr = 4'hf; set = 4'hf; inc = 4'hf; dec = 4'hf; ds = 8'd77;
    tick();
    chk("rst q_all", q_all[0] | q_all[1], 32'd0);
    chk("rst q_out", 32'({q_out[1], q_out[0]}), 32'd0);
    chk("rst tc/ovf", 32'({tc[1], tc[0], ovf[1], ovf[0]}), 32'd0);
    rst_n = 1'b1; idle();
    tick();

    for (int n = 0; n < 400; n++) begin
      rst_n = ($urandom_range(0, 49) != 0);
      clr = 4'($urandom & $urandom & $urandom);
      set = 4'($urandom & $urandom);
      inc = 4'($urandom);
      dec = 4'($urandom & $urandom);
      lim = 8'($urandom);
      ds = $urandom_range(0, 1) ? lim : 8'($urandom);
      di = $urandom_range(0, 1) ? 8'($urandom_range(0, 3)) : 8'($urandom);
      dd = $urandom_range(0, 1) ? 8'($urandom_range(0, 3)) : 8'($urandom);
      rd_sel = 3'($urandom);
      tick();
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
